// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC frame scheduler: FSM states,
// DAC command nibbles and the sample width.
package dac_sched_pkg;

    localparam int SAMPLE_W = 12;

    localparam logic [3:0] CMD_A = 4'b0011;
    localparam logic [3:0] CMD_B = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_WAIT_A,
        ST_SEND_B,
        ST_WAIT_B,
        ST_LATCH
    } sched_state_t;

    function automatic logic [15:0] cmd_word(input logic [3:0] cmd,
                                             input logic [SAMPLE_W-1:0] sample);
        return {cmd, sample};
    endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Frame-rate timer: registered one-cycle tick every RATE_DIV clk cycles while
// enabled; the down-counter is parked at its reload value while disabled.
module rate_tick_gen #(
    parameter int RATE_DIV = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] RELOAD = 16'(RATE_DIV - 1);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RELOAD;
            tick  <= 1'b0;
        end else if (!enable) begin
            count <= RELOAD;
            tick  <= 1'b0;
        end else if (count == 16'd0) begin
            count <= RELOAD;
            tick  <= 1'b1;
        end else begin
            count <= count - 16'd1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/dac_frame_scheduler.sv
// Dual-channel DAC update sequencer: snapshots both channel samples on each
// frame tick, sends word A then word B over the SPI start/done handshake and
// pulses LDAC. Define LDAC_SYNC_EN to enable the synchronous LDAC latch phase.
module dac_frame_scheduler
    import dac_sched_pkg::*;
#(
    parameter int RATE_DIV    = 2000,
    parameter int LDAC_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] a_data,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [SAMPLE_W-1:0] b_data,
    input  logic                b_valid,
    output logic                b_ready,
    output logic [15:0]         spi_word,
    output logic                spi_start,
    input  logic                spi_done,
    output logic                ldac,
    output logic                frame_tick,
    output logic                overrun,
    input  logic                overrun_clr
);

    if (RATE_DIV < 2 || RATE_DIV > 65535) begin : g_bad_rate_div
        $error("RATE_DIV must be in 2..65535");
    end
    if (LDAC_CYCLES < 1 || LDAC_CYCLES > 15) begin : g_bad_ldac_cycles
        $error("LDAC_CYCLES must be in 1..15");
    end

    sched_state_t        state, state_nxt;
    logic [SAMPLE_W-1:0] shadow_a, shadow_b;
    logic [SAMPLE_W-1:0] snap_a, snap_b;
    logic                tick;

    rate_tick_gen #(
        .RATE_DIV (RATE_DIV)
    ) u_rate_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign frame_tick = tick;
    assign a_ready    = 1'b1;
    assign b_ready    = 1'b1;

    // Shadows always accept; a write in the tick cycle lands after the snapshot.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_a <= '0;
            shadow_b <= '0;
        end else begin
            if (a_valid) shadow_a <= a_data;
            if (b_valid) shadow_b <= b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            snap_a <= '0;
            snap_b <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && tick) begin
                snap_a <= shadow_a;
                snap_b <= shadow_b;
            end
        end
    end

    // Set has priority over clear so an overrun is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (tick && state != ST_IDLE) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef LDAC_SYNC_EN
    localparam logic [3:0] LDAC_LAST = 4'(LDAC_CYCLES - 1);

    logic [3:0] latch_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            latch_cnt <= '0;
        end else if (state != ST_LATCH) begin
            latch_cnt <= LDAC_LAST;
        end else begin
            latch_cnt <= latch_cnt - 4'd1;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        spi_start = 1'b0;
        spi_word  = 16'h0000;
`ifdef LDAC_SYNC_EN
        ldac      = 1'b1;
`else
        ldac      = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (tick) state_nxt = ST_SEND_A;
            end
            ST_SEND_A: begin
                spi_start = 1'b1;
                spi_word  = cmd_word(CMD_A, snap_a);
                state_nxt = ST_WAIT_A;
            end
            ST_WAIT_A: begin
                spi_word = cmd_word(CMD_A, snap_a);
                if (spi_done) state_nxt = ST_SEND_B;
            end
            ST_SEND_B: begin
                spi_start = 1'b1;
                spi_word  = cmd_word(CMD_B, snap_b);
                state_nxt = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                spi_word = cmd_word(CMD_B, snap_b);
`ifdef LDAC_SYNC_EN
                if (spi_done) state_nxt = ST_LATCH;
`else
                if (spi_done) state_nxt = ST_IDLE;
`endif
            end
`ifdef LDAC_SYNC_EN
            ST_LATCH: begin
                spi_word = cmd_word(CMD_B, snap_b);
                ldac     = 1'b0;
                if (latch_cnt == 4'd0) state_nxt = ST_IDLE;
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/dac_frame_scheduler.md
# dac_frame_scheduler

Sequences dual-channel DAC updates for the wavegen datapath. Captures the latest 12-bit samples from the channel A and channel B waveform sources, and on each sample-rate tick issues two 16-bit command words to the SPI serializer through a start/done handshake. After both words are sent it generates the LDAC latch pulse, so both DAC outputs change together. It sits between the waveform generators and the SPI engine and owns all update timing.

## Interface
- RATE_DIV, 2000: clk cycles per update frame; legal range 2..65535.
- LDAC_CYCLES, 2: clk cycles LDAC is held low; legal range 1..15.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  frame ticks are generated only while high.
- a_data  in  12  channel A unsigned sample.
- a_valid  in  1  a_data is valid this cycle.
- a_ready  out  1  channel A shadow register can accept a sample.
- b_data  in  12  channel B unsigned sample.
- b_valid  in  1  b_data is valid this cycle.
- b_ready  out  1  channel B shadow register can accept a sample.
- spi_word  out  16  command word for the serializer.
- spi_start  out  1  one-cycle request to send spi_word.
- spi_done  in  1  one-cycle pulse from the serializer when a word is finished (CS raised).
- ldac  out  1  DAC latch, active low.
- frame_tick  out  1  one-cycle pulse marking the start of each frame.
- overrun  out  1  sticky flag: a tick arrived while a frame was still in progress.
- overrun_clr  in  1  clears overrun.

## Operation
- Shadow registers: a_ready and b_ready are constant 1. A cycle with a_valid set loads a_data into shadow_a; b_valid likewise loads shadow_b. The last write before a tick wins.
- Tick timer: a down-counter reloads to RATE_DIV-1. When it reaches 0 with enable high, frame_tick pulses. While enable is low the counter is held at RATE_DIV-1.
- On tick in IDLE: shadow_a and shadow_b are copied into snap_a and snap_b. A shadow write in the same cycle does not reach the snapshot; it lands in the shadow for the next frame.
- Command words:
  - Word A = {4'b0011, snap_a}.
  - Word B = {4'b1011, snap_b}.
  - No arithmetic is applied to the samples.
- FSM states: IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, LATCH.
  - IDLE → SEND_A on tick.
  - SEND_A: spi_start=1 and spi_word=A for one cycle, then → WAIT_A.
  - WAIT_A → SEND_B on spi_done.
  - SEND_B: spi_start=1 and spi_word=B for one cycle, then → WAIT_B.
  - WAIT_B → LATCH on spi_done.
  - LATCH holds ldac=0 for LDAC_CYCLES cycles, then → IDLE.
- spi_word holds its value from the SEND cycle until the following spi_done.
- spi_done outside WAIT_A or WAIT_B is ignored.
- A tick outside IDLE sets overrun and is dropped; the frame in progress completes normally.
- If overrun_clr and an overrun set occur in the same cycle, the set wins.
- enable falling mid-frame: the current frame completes, then the FSM stays in IDLE.

## Timing
- Reset values:
  - FSM = IDLE, timer = RATE_DIV-1.
  - spi_start=0, spi_word=0, ldac=1, frame_tick=0, overrun=0.
  - Shadow and snapshot registers = 0.
  - a_ready=b_ready=1 (constant).
- Reset mid-frame aborts immediately with the values above. The serializer is expected to share the same reset.
- Latencies:
  - tick → spi_start (word A): 1 cycle.
  - spi_done (A) → spi_start (B): 1 cycle.
  - spi_done (B) → ldac low: 1 cycle.
- First tick occurs RATE_DIV cycles after reset release with enable high.
- RATE_DIV must exceed the frame length (2×serializer word time + LDAC_CYCLES + 5); otherwise every other tick raises overrun.

## Configuration
- LDAC_SYNC_EN defined: the LATCH state exists and ldac pulses low as described.
- LDAC_SYNC_EN undefined:
  - ldac is tied to 0, so the DAC transfers each word when CS rises.
  - WAIT_B → IDLE directly; the LDAC_CYCLES parameter is unused.

## Structure
- Package dac_sched_pkg holds:
  - the state enum;
  - the command nibble constants CMD_A=4'b0011 and CMD_B=4'b1011;
  - the shared sample width constant SAMPLE_W=12.
- One natural sub-module: rate_tick_gen, which contains the tick timer with its enable and reload behaviour.

## Test plan
- Basic frame: RATE_DIV=50, a=12'hABC, b=12'h123, bench serializer answers spi_done 20 cycles after each start → words 16'h3ABC then 16'hB123, ldac low for 2 cycles, frame_tick every 50 cycles.
- Snapshot race: a_valid with 12'h7FF in the tick cycle, shadow previously 12'h100 → this frame sends 16'h3100 and the next frame sends 16'h37FF.
- Overrun: RATE_DIV=30 with 20-cycle word time → overrun sets on the second tick and every frame still completes. Pulse overrun_clr → flag clears.
- Enable drop: drop enable during WAIT_A → word B and ldac still complete, then no further spi_start.
- Reset mid-frame: assert reset in WAIT_B → next cycle ldac=1, spi_start=0, FSM=IDLE, and the next frame starts RATE_DIV cycles after reset release.
- Macro undefined: the same stimulus as the basic frame gives ldac constantly 0, and the second frame's spi_start is not delayed by LDAC_CYCLES.
